// File: rtl/picorv32_mem_responder.sv
// CPU-facing word memory for the picorv32 native interface: programmable wait states,
// backdoor program load under reset, TOHOST verdict mailbox, out-of-range flag, fetch counter.
module picorv32_mem_responder #(
  parameter int unsigned MEM_WORDS   = 1024,
  parameter int unsigned WAIT_CYCLES = 1,
  parameter logic [31:0] TOHOST_ADDR = 32'h1000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_valid,
  input  logic        mem_instr,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  input  logic        load_en,
  input  logic [31:0] load_addr,
  input  logic [31:0] load_data,
  output logic        test_done,
  output logic [31:0] test_code,
  output logic        err_oob,
  output logic [31:0] fetch_count
);

  localparam int unsigned AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  typedef struct packed {
    logic        instr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } req_t;

  state_t      state;
  req_t        req_q;
  req_t        cur;
  logic [3:0]  cnt;
  logic        commit;
  logic        is_write;
  logic        in_range;
  logic        is_tohost;
  logic [AW-1:0] word_idx;
  logic [31:0] mem [MEM_WORDS];

  function automatic logic [31:0] lane_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++)
      if (strb[i]) res[8*i +: 8] = new_val[8*i +: 8];
    return res;
  endfunction

  // With zero wait states the access completes on the accepting edge, so it must use the
  // live request; otherwise it uses the copy latched at acceptance.
  always_comb begin
    cur       = (state == IDLE) ? req_t'{instr: mem_instr, addr: mem_addr,
                                         wdata: mem_wdata, wstrb: mem_wstrb} : req_q;
    commit    = ((state == IDLE) && mem_valid && (WAIT_CYCLES == 0)) ||
                ((state == WAIT) && (cnt == 4'd1));
    is_write  = |cur.wstrb;
    in_range  = {2'b00, cur.addr[31:2]} < MEM_WORDS;
    is_tohost = (cur.addr == TOHOST_ADDR);
    word_idx  = cur.addr[AW+1:2];
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples
  // the pre-edge values of its neighbours regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      req_q       <= '0;
      cnt         <= '0;
      mem_ready   <= 1'b0;
      mem_rdata   <= '0;
      test_done   <= 1'b0;
      test_code   <= '0;
      err_oob     <= 1'b0;
      fetch_count <= '0;
    end else begin
      mem_ready <= commit;
      case (state)
        IDLE: if (mem_valid) begin
          req_q <= cur;
          cnt   <= 4'(WAIT_CYCLES);
          state <= (WAIT_CYCLES == 0) ? RESP : WAIT;
        end
        WAIT: if (cnt == 4'd1) state <= RESP;
              else             cnt   <= cnt - 4'd1;
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase

      if (commit) begin
        if (cur.instr) fetch_count <= fetch_count + 32'd1;
        if (!is_write) begin
          if (in_range)       mem_rdata <= mem[word_idx];
          else if (is_tohost) mem_rdata <= test_code;
          else begin
            mem_rdata <= '0;
            err_oob   <= 1'b1;
          end
        end else if (!in_range) begin
          if (is_tohost) begin
            test_code <= lane_merge(test_code, cur.wdata, cur.wstrb);
            test_done <= 1'b1;
          end else begin
            err_oob <= 1'b1;
          end
        end
      end
    end
  end

  // NOTE: the array is deliberately not reset; reset is the window in which the backdoor
  // loads the program, and clearing it would need a per-word reset network.
  always_ff @(posedge clk) begin
    if (reset) begin
      if (load_en && (load_addr < MEM_WORDS)) mem[load_addr[AW-1:0]] <= load_data;
    end else if (commit && is_write && in_range) begin
      for (int i = 0; i < 4; i++)
        if (cur.wstrb[i]) mem[word_idx][8*i +: 8] <= cur.wdata[8*i +: 8];
    end
  end

endmodule
